alarm_buzzer_ctrl: RTL
======================

Name: alarm_buzzer_ctrl

Overview:
- Downstream consumer of the debounced motion-detect level; sits between the motion debouncer and the physical piezo pin.
- Arms/disarms the alarm and latches an alarm on motion.
- Holds the alarm for a minimum quiet period after motion stops and supports a user silence pulse.
- Drives the buzzer with a gated square-wave tone in an on/off beep cadence (50 MHz system clock).

Parameters:
- TONE_HALF, 12500: clk cycles per tone half-period (2 kHz tone at 50 MHz); minimum 1.
- BEEP_ON, 12500000: cycles the tone is gated on per beep period (250 ms).
- BEEP_OFF, 12500000: cycles of silence per beep period (250 ms).
- HOLD_CYCLES, 250000000: consecutive motion-free cycles required to leave ALARM/SILENCED (5 s).
- CNT_W, 28: width of the phase and hold counters; must hold max(BEEP_ON+BEEP_OFF, HOLD_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- arm  input  1  level; 1 = system armed; synchronous to clk.
- motion  input  1  debounced motion level; synchronous to clk.
- silence  input  1  single-cycle pulse from the user button conditioner.
- buzzer_out  output  1  tone drive to the piezo.
- alarm_active  output  1  1 while state is ALARM.
- state  output  2  current FSM state code (debug/LED).

Behaviour:
- Reset (async) values:
  - state=DISARMED(2'd0).
  - buzzer_out=0, alarm_active=0.
  - All internal counters 0; tone register 0.
- States:
  - DISARMED=0, ARMED=1, ALARM=2, SILENCED=3.
  - All transitions occur on the clock edge following the qualifying input.
- Transition priority, evaluated every cycle: arm=0 > silence > motion/hold rules.
- DISARMED:
  - arm=1 -> ARMED.
  - motion and silence are ignored.
- ARMED:
  - arm=0 -> DISARMED.
  - Otherwise motion=1 -> ALARM.
- ALARM:
  - arm=0 -> DISARMED.
  - Otherwise silence=1 -> SILENCED.
  - Otherwise, when the hold counter equals HOLD_CYCLES-1 with motion=0 -> ARMED.
- SILENCED:
  - arm=0 -> DISARMED.
  - Otherwise, when the hold counter equals HOLD_CYCLES-1 with motion=0 -> ARMED.
  - Further silence pulses have no effect.
  - Motion only restarts the quiet period; it never re-enters ALARM directly.
- Hold counter:
  - Cleared to 0 on any state entry and on any cycle with motion=1.
  - Increments on each motion=0 cycle while in ALARM or SILENCED.
  - Never wraps past HOLD_CYCLES-1.
- Beep phase counter:
  - Runs only in ALARM.
  - Cleared to 0 on ALARM entry.
  - Counts 0..BEEP_ON+BEEP_OFF-1, then wraps to 0.
  - On-phase means count < BEEP_ON.
- Tone:
  - Tone register is set to 1 and the tone counter cleared at ALARM entry and at every phase-counter wrap.
  - During on-phase, the tone register toggles after every TONE_HALF cycles.
  - The tone register is held at 0 during off-phase.
- buzzer_out = tone register AND (state==ALARM) AND on-phase.
  - It is forced 0 in every other state.
  - It is decoded from registers only; no input→output combinational path.
- alarm_active = (state==ALARM), decoded from the state register.
- Latency:
  - motion rising in ARMED at edge n gives state=ALARM, alarm_active=1 and buzzer_out=1 after edge n+1.
  - buzzer_out stays 1 for TONE_HALF cycles, then alternates.
- Simultaneous events:
  - arm falling together with silence or motion -> DISARMED.
  - silence coinciding with hold expiry -> SILENCED.
- Reset mid-alarm: buzzer_out drops immediately (async); FSM returns to DISARMED.

Optional Feature:
- Macro: ALARM_COUNT_EN.
- Defined:
  - Adds output port alarm_count (8 bits).
  - Increments by 1 on each ARMED->ALARM transition.
  - Saturates at 255.
  - Cleared only by reset.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan (TONE_HALF=2, BEEP_ON=8, BEEP_OFF=4, HOLD_CYCLES=10):
- Arm/alarm/cadence:
  - reset, arm=1 for 1 cycle -> state=1.
  - Then motion=1 at cycle 5 -> state=2 and alarm_active=1 after the next edge.
  - buzzer_out pattern 1,1,0,0,1,1,0,0 then 0,0,0,0, repeating every 12 cycles.
- Hold period:
  - In ALARM, drop motion at cycle 20 -> state stays 2 for 10 cycles, then 1.
  - A 1-cycle motion blip at cycle 25 restarts the 10-cycle count.
- Silence:
  - silence pulse in ALARM -> state=3, buzzer_out=0 next cycle.
  - motion held 1 -> stays 3.
  - motion=0 for 10 cycles -> state=1.
- Disarm priority:
  - In ALARM, arm=0 and silence=1 in the same cycle -> state=0, buzzer_out=0.
  - motion=1 while DISARMED -> no change.
- Async reset:
  - Assert reset mid beep-on between clock edges -> buzzer_out, alarm_active and state go to 0 immediately.
  - After release with arm=1 -> ARMED after one edge.
- ALARM_COUNT_EN build:
  - 3 ARMED->ALARM entries -> alarm_count=3.
  - 300 entries -> alarm_count=255.
  - Silence/re-arm cycles do not increment.

Source files
------------

// File: rtl/alarm_buzzer_ctrl.sv
// Alarm arm/latch/hold FSM driving a gated, beeping piezo tone.
// Optional build macro ALARM_COUNT_EN adds a saturating ARMED->ALARM entry counter (alarm_count).
module alarm_buzzer_ctrl #(
  parameter int TONE_HALF   = 12500,
  parameter int BEEP_ON     = 12500000,
  parameter int BEEP_OFF    = 12500000,
  parameter int HOLD_CYCLES = 250000000,
  parameter int CNT_W       = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arm,
  input  logic       motion,
  input  logic       silence,
  output logic       buzzer_out,
  output logic       alarm_active,
`ifdef ALARM_COUNT_EN
  output logic [7:0] alarm_count,
`endif
  output logic [1:0] state
);

  localparam logic [1:0] DISARMED = 2'd0;
  localparam logic [1:0] ARMED    = 2'd1;
  localparam logic [1:0] ALARM    = 2'd2;
  localparam logic [1:0] SILENCED = 2'd3;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(BEEP_ON + BEEP_OFF - 1);
  localparam logic [CNT_W-1:0] ON_LEN     = CNT_W'(BEEP_ON);
  localparam logic [CNT_W-1:0] TONE_LAST  = CNT_W'(TONE_HALF - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] phase_cnt, phase_inc;
  logic [CNT_W-1:0] tone_cnt;
  logic             tone_q;
  logic             hold_done;
  logic             entering_alarm;

  assign hold_done      = (hold_cnt == HOLD_LAST) && !motion;
  assign entering_alarm = (state_d == ALARM) && (state_q != ALARM);
  assign phase_inc      = phase_cnt + CNT_W'(1);

  // Priority: disarm beats silence beats the motion/hold rules.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DISARMED: if (arm) state_d = ARMED;
      ARMED: begin
        if (!arm)        state_d = DISARMED;
        else if (motion) state_d = ALARM;
      end
      ALARM: begin
        if (!arm)           state_d = DISARMED;
        else if (silence)   state_d = SILENCED;
        else if (hold_done) state_d = ARMED;
      end
      SILENCED: begin
        if (!arm)           state_d = DISARMED;
        else if (hold_done) state_d = ARMED;
      end
      default: state_d = DISARMED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= DISARMED;
    else       state_q <= state_d;
  end

  // Quiet-period counter; saturates at its terminal value rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if ((state_d != state_q) || motion) begin
      hold_cnt <= '0;
    end else if (((state_q == ALARM) || (state_q == SILENCED)) && (hold_cnt != HOLD_LAST)) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

  // Beep cadence and tone generator; every beep period restarts with tone high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_cnt <= '0;
      tone_cnt  <= '0;
      tone_q    <= 1'b0;
    end else if (entering_alarm) begin
      phase_cnt <= '0;
      tone_cnt  <= '0;
      tone_q    <= 1'b1;
    end else if (state_d == ALARM) begin
      if (phase_cnt == PHASE_LAST) begin
        phase_cnt <= '0;
        tone_cnt  <= '0;
        tone_q    <= 1'b1;
      end else begin
        phase_cnt <= phase_inc;
        if (phase_inc < ON_LEN) begin
          if (tone_cnt == TONE_LAST) begin
            tone_cnt <= '0;
            tone_q   <= ~tone_q;
          end else begin
            tone_cnt <= tone_cnt + CNT_W'(1);
          end
        end else begin
          tone_cnt <= '0;
          tone_q   <= 1'b0;
        end
      end
    end else begin
      phase_cnt <= '0;
      tone_cnt  <= '0;
      tone_q    <= 1'b0;
    end
  end

`ifdef ALARM_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      alarm_count <= 8'd0;
    else if ((state_q == ARMED) && (state_d == ALARM) && (alarm_count != 8'hFF))
      alarm_count <= alarm_count + 8'd1;
  end
`endif

  assign state        = state_q;
  assign alarm_active = (state_q == ALARM);
  assign buzzer_out   = tone_q && (state_q == ALARM) && (phase_cnt < ON_LEN);

endmodule
